// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for a common-anode 7-seg display.
// Ports: clk, reset (sync, active-high), enable, load, value[4*DIGITS], lz_blank
//        -> bcd[4], seg_en, digit_sel[DIGITS] (active-low), frame_done (pulse).
module seg_scan #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    output logic [3:0]            bcd,
    output logic                  seg_en,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] ON_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        BLANK
    } state_t;

    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [4*DIGITS-1:0]   shadow, active;
    logic                  pending;
    logic                  lz_q;
    logic [DIGITS-1:0]     hz;
    logic                  run;
    logic                  supp;
    logic [3:0]            nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                idx_n = '0;
                cnt_n = '0;
                if (enable) begin
                    state_n = ON;
                end
            end
            ON: begin
                if (!enable) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == ON_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == BL_LAST) begin
                    state_n = ON;
                    cnt_n   = '0;
                    idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Last BLANK cycle of the last digit closes the frame.
    assign frame_done = (state == BLANK) && (idx == IDX_LAST) && (cnt == BL_LAST);

    // active only changes at frame boundaries; a load landing on the
    // boundary itself bypasses shadow so it shows in the very next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            lz_q    <= 1'b0;
        end else begin
            lz_q <= lz_blank;
            if (frame_done) begin
                if (load) begin
                    active  <= value;
                    shadow  <= value;
                    pending <= 1'b0;
                end else if (pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                end
            end else if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

    // hz[i]: nibbles i..DIGITS-1 of active are all zero.
    always_comb begin
        run = 1'b1;
        hz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run   = run && (active[4*i +: 4] == 4'd0);
            hz[i] = run;
        end
    end

    assign nib  = active[{idx, 2'b00} +: 4];
    assign supp = lz_q && (idx != '0) && hz[idx];

    always_comb begin
        bcd       = 4'd0;
        seg_en    = 1'b0;
        digit_sel = '1;
        if (state == ON) begin
            bcd = nib;
            if (!supp) begin
                seg_en    = 1'b1;
                digit_sel = ~(DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan (DIGITS=4, CLK_DIV=4, BLANK=1).
// Expected per-cycle outputs are queued as stimulus is driven, popped each cycle.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  bcd;
    logic        seg_en;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic       en;
        logic [3:0] bcd;
        logic       fd;
    } exp_t;

    exp_t q[$];

    seg_scan #(
        .DIGITS(4),
        .CLK_DIV(4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .load(load),
        .value(value),
        .lz_blank(lz_blank),
        .bcd(bcd),
        .seg_en(seg_en),
        .digit_sel(digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic push_on(input logic [15:0] v, input logic lz, input int d);
        exp_t e;
        logic s;
        s = lz && (d != 0) && ((v >> (4 * d)) == 16'd0);
        e.sel = s ? 4'hF : ~(4'b0001 << d);
        e.en  = !s;
        e.bcd = v[4*d +: 4];
        e.fd  = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_blank(input int d);
        exp_t e;
        e.sel = 4'hF;
        e.en  = 1'b0;
        e.bcd = 4'd0;
        e.fd  = (d == 3);
        q.push_back(e);
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.sel = 4'hF;
        e.en  = 1'b0;
        e.bcd = 4'd0;
        e.fd  = 1'b0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic lz);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) push_on(v, lz, d);
            push_blank(d);
        end
    endtask

    task automatic check_cycles(input int n, input string name);
        exp_t e;
        exp_t a;
        for (int i = 0; i < n; i++) begin
            a = {digit_sel, seg_en, bcd, frame_done};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s cyc%0d: no expectation queued, got %h", name, i, a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cyc%0d: sel=%b en=%b bcd=%h fd=%b, want sel=%b en=%b bcd=%h fd=%b",
                             name, i, a.sel, a.en, a.bcd, a.fd, e.sel, e.en, e.bcd, e.fd);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        lz_blank = 1'b0;
        @(negedge clk);
        push_dark(2);
        check_cycles(2, "reset");
    endtask

    task automatic test_scan();
        reset  = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        value  = 16'h12AF;
        push_dark(1);
        push_frame(16'h0000, 1'b0);
        push_frame(16'h12AF, 1'b0);
        check_cycles(1, "scan");
        load = 1'b0;
        check_cycles(40, "scan");
    endtask

    task automatic test_last_load_wins();
        push_frame(16'h12AF, 1'b0);
        push_frame(16'h2222, 1'b0);
        load  = 1'b1;
        value = 16'h1111;
        check_cycles(1, "last_load");
        load = 1'b0;
        check_cycles(4, "last_load");
        load  = 1'b1;
        value = 16'h2222;
        check_cycles(1, "last_load");
        load = 1'b0;
        check_cycles(34, "last_load");
    endtask

    task automatic test_load_on_boundary();
        push_frame(16'h2222, 1'b0);
        push_frame(16'h0305, 1'b0);
        check_cycles(19, "boundary");
        load  = 1'b1;
        value = 16'h0305;
        check_cycles(1, "boundary");
        load = 1'b0;
        check_cycles(20, "boundary");
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        load     = 1'b1;
        value    = 16'h0040;
        push_frame(16'h0305, 1'b1);
        push_frame(16'h0040, 1'b1);
        check_cycles(1, "lz");
        load = 1'b0;
        check_cycles(20, "lz");
        load  = 1'b1;
        value = 16'h0000;
        push_frame(16'h0000, 1'b1);
        check_cycles(1, "lz_zero");
        load = 1'b0;
        check_cycles(38, "lz_zero");
        load  = 1'b1;
        value = 16'h4321;
        for (int c = 0; c < 4; c++) push_on(16'h0000, 1'b1, 0);
        push_blank(0);
        push_on(16'h0000, 1'b1, 1);
        for (int c = 0; c < 3; c++) push_on(16'h0000, 1'b0, 1);
        push_blank(1);
        for (int d = 2; d < 4; d++) begin
            for (int c = 0; c < 4; c++) push_on(16'h0000, 1'b0, d);
            push_blank(d);
        end
        push_frame(16'h4321, 1'b0);
        check_cycles(1, "lz_toggle");
        load = 1'b0;
        check_cycles(4, "lz_toggle");
        lz_blank = 1'b0;
        check_cycles(35, "lz_toggle");
    endtask

    task automatic test_enable_drop();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) push_on(16'h4321, 1'b0, d);
            push_blank(d);
        end
        push_on(16'h4321, 1'b0, 2);
        push_on(16'h4321, 1'b0, 2);
        check_cycles(11, "en_drop");
        enable = 1'b0;
        check_cycles(1, "en_drop");
        push_dark(3);
        check_cycles(3, "en_dark");
        enable = 1'b1;
        push_dark(1);
        push_frame(16'h4321, 1'b0);
        check_cycles(21, "en_restart");
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c < 4; c++) push_on(16'h4321, 1'b0, 0);
        push_blank(0);
        load  = 1'b1;
        value = 16'h9999;
        check_cycles(1, "mid_reset");
        load = 1'b0;
        check_cycles(3, "mid_reset");
        reset = 1'b1;
        check_cycles(1, "mid_reset");
        push_dark(2);
        check_cycles(2, "mid_reset_out");
        reset = 1'b0;
        push_dark(1);
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        check_cycles(41, "post_reset");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_last_load_wins();
        test_load_on_boundary();
        test_lz_blank();
        test_enable_drop();
        test_reset_mid_frame();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expectations unconsumed, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
